// File: rtl/data_mem_v2.sv
// data_mem_v2 -- byte-addressable 32-bit data memory for the RV32I load/store
// stage, with an optional memory-mapped LED register.
//
// Optional feature macro: DATA_MEM_LED_EN
//   defined   : a store whose word address matches LED_ADDR[31:2] also loads
//               led with byte 0 of the merged word (the RAM is written too).
//   undefined : led is tied to 8'h00 and LED_ADDR is ordinary memory.
//
// Ports:
//   clk        in   1   rising-edge clock
//   reset      in   1   asynchronous, active-high reset
//   addr       in   32  byte address of the access
//   write_data in   32  store data, right-aligned (byte [7:0], half [15:0])
//   memwrite   in   1   store request (wins over memread)
//   memread    in   1   load request
//   sign_mask  in   4   [3] signed load, [2:0] size 001 byte / 011 half / 111 word
//   read_data  out  32  extended load result, held until the next load completes
//   led        out  8   LED register value
//   clk_stall  out  1   high while a request is being processed
//
// Handshake: memread/memwrite form a one-cycle request pulse. A request is
// accepted on the posedge where the FSM is IDLE; clk_stall acts as "busy" and
// is asserted combinationally from the request cycle until the FSM is back in
// IDLE. Requests seen while busy are ignored.
//
// Timing: load result lands at the 3rd posedge (acceptance = 1st); a store
// reaches the RAM at the 4th posedge. The FSM state is kept in the 'state'
// signal (state_t) for observation.

module data_mem_v2 #(
  parameter int          DEPTH    = 1024,
  parameter logic [31:0] LED_ADDR = 32'h0000_2000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  input  logic        memwrite,
  input  logic        memread,
  input  logic [3:0]  sign_mask,
  output logic [31:0] read_data,
  output logic [7:0]  led,
  output logic        clk_stall
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    READ_BUFFER = 2'd1,
    READ        = 2'd2,
    WRITE       = 2'd3
  } state_t;

  state_t state;
  state_t next_state;

  logic [31:0] mem [DEPTH];
  logic [31:0] ram_q;     // synchronous RAM read port output
  logic [31:0] word_q;    // fetched word, later the merged store word
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  mask_q;
  logic        op_write;

  logic        req;
  logic        accept;
  logic        is_byte;
  logic        is_half;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_val;
  logic [31:0] merged;

  assign req       = memread | memwrite;
  assign accept    = (state == IDLE) && req;
  assign clk_stall = (state != IDLE) || req;

  // Size codes other than byte/halfword fall through to a word access.
  assign is_byte = (mask_q[2:0] == 3'b001);
  assign is_half = (mask_q[2:0] == 3'b011);

  // ---------------- FSM ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:        if (req) next_state = READ_BUFFER;
      READ_BUFFER: next_state = READ;
      READ:        next_state = op_write ? WRITE : IDLE;
      WRITE:       next_state = IDLE;
      default:     next_state = IDLE;
    endcase
  end

  // ---------------- load lane extraction ----------------
  always_comb begin
    byte_sel = 8'h00;
    case (addr_q[1:0])
      2'd0: byte_sel = word_q[7:0];
      2'd1: byte_sel = word_q[15:8];
      2'd2: byte_sel = word_q[23:16];
      2'd3: byte_sel = word_q[31:24];
      default: byte_sel = 8'h00;
    endcase
    half_sel = addr_q[1] ? word_q[31:16] : word_q[15:0];
    load_val = word_q;
    if (is_byte)      load_val = {{24{mask_q[3] & byte_sel[7]}}, byte_sel};
    else if (is_half) load_val = {{16{mask_q[3] & half_sel[15]}}, half_sel};
  end

  // ---------------- store lane merge ----------------
  always_comb begin
    merged = word_q;
    if (is_byte) begin
      case (addr_q[1:0])
        2'd0: merged[7:0]   = wdata_q[7:0];
        2'd1: merged[15:8]  = wdata_q[7:0];
        2'd2: merged[23:16] = wdata_q[7:0];
        2'd3: merged[31:24] = wdata_q[7:0];
        default: merged = word_q;
      endcase
    end else if (is_half) begin
      if (addr_q[1]) merged[31:16] = wdata_q[15:0];
      else           merged[15:0]  = wdata_q[15:0];
    end else begin
      merged = wdata_q;
    end
  end

  // ---------------- RAM (not reset) ----------------
  // The read is issued on the acceptance edge using the live address; upper
  // address bits beyond the array simply alias.
  always_ff @(posedge clk) begin
    if (accept)         ram_q <= mem[addr[AW+1:2]];
    if (state == WRITE) mem[addr_q[AW+1:2]] <= word_q;
  end

  // ---------------- request latch and datapath ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q    <= '0;
      wdata_q   <= '0;
      mask_q    <= '0;
      op_write  <= 1'b0;
      word_q    <= '0;
      read_data <= '0;
    end else begin
      if (accept) begin
        addr_q   <= addr;
        wdata_q  <= write_data;
        mask_q   <= sign_mask;
        op_write <= memwrite;
      end
      if (state == READ_BUFFER) word_q <= ram_q;
      if (state == READ) begin
        if (op_write) word_q    <= merged;
        else          read_data <= load_val;
      end
    end
  end

  // ---------------- LED register ----------------
`ifdef DATA_MEM_LED_EN
  logic [7:0] led_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      led_q <= 8'h00;
    end else if ((state == WRITE) && (addr_q[31:2] == LED_ADDR[31:2])) begin
      led_q <= word_q[7:0];
    end
  end

  assign led = led_q;
`else
  // Upper address bits only matter for the LED decode.
  logic unused_addr_bits;
  assign unused_addr_bits = ^addr_q[31:AW+2];
  assign led = 8'h00;
`endif

endmodule

// File: tb/tb_data_mem_v2.sv
// Testbench for data_mem_v2: reset checks, a table of load/store vectors with
// stall-length and result checks through an expected-value queue, a random
// word store/load pass, and hand sequences for LED, hold and mid-store reset.

module tb_data_mem_v2;

  logic        clk;
  logic        reset;
  logic [31:0] addr;
  logic [31:0] write_data;
  logic        memwrite;
  logic        memread;
  logic [3:0]  sign_mask;
  logic [31:0] read_data;
  logic [7:0]  led;
  logic        clk_stall;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] exp_q[$];

  typedef struct {
    bit          wr;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  m;
    logic [31:0] e;
    string       name;
  } vec_t;

  vec_t vecs[$];

  data_mem_v2 dut (
    .clk        (clk),
    .reset      (reset),
    .addr       (addr),
    .write_data (write_data),
    .memwrite   (memwrite),
    .memread    (memread),
    .sign_mask  (sign_mask),
    .read_data  (read_data),
    .led        (led),
    .clk_stall  (clk_stall)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic vec_t mk(input bit wr, input logic [31:0] a, input logic [31:0] d,
                              input logic [3:0] m, input logic [31:0] e, input string name);
    vec_t v;
    v.wr = wr; v.a = a; v.d = d; v.m = m; v.e = e; v.name = name;
    return v;
  endfunction

  // Drive one request pulse, measure how many posedges clk_stall covers,
  // then compare the load result against the scoreboard.
  task automatic do_op(input vec_t v);
    int          cyc;
    logic [31:0] exp;
    @(negedge clk);
    addr       = v.a;
    write_data = v.d;
    sign_mask  = v.m;
    memwrite   = v.wr;
    memread    = !v.wr;
    if (!v.wr) exp_q.push_back(v.e);
    #1;
    check({v.name, "_stall_rise"}, {31'd0, clk_stall}, 32'd1);
    cyc = 0;
    do begin
      @(posedge clk);
      cyc++;
      #1;
      memwrite = 1'b0;
      memread  = 1'b0;
    end while (clk_stall && cyc < 20);
    check({v.name, "_stall_edges"}, cyc, v.wr ? 32'd4 : 32'd3);
    if (!v.wr) begin
      if (exp_q.size() > 0) begin
        exp = exp_q.pop_front();
        check({v.name, "_rdata"}, read_data, exp);
      end else begin
        check({v.name, "_queue_empty"}, 32'd0, 32'd1);
      end
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] rnd_data [8];
    logic [7:0]  led_exp;
    int          cyc;

    reset      = 1'b1;
    addr       = '0;
    write_data = '0;
    memwrite   = 1'b0;
    memread    = 1'b0;
    sign_mask  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_read_data", read_data, 32'h0);
    check("reset_led", {24'd0, led}, 32'h0);
    check("reset_stall", {31'd0, clk_stall}, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // wr, addr, data, mask, expected load, name
    vecs.push_back(mk(1, 32'h400,  32'h0,        4'b0111, 32'h0,        "clr_400"));
    vecs.push_back(mk(1, 32'h400,  32'hAAA,      4'b0001, 32'h0,        "sb_400"));
    vecs.push_back(mk(0, 32'h400,  32'h0,        4'b1001, 32'hFFFF_FFAA, "lb_400"));
    vecs.push_back(mk(0, 32'h400,  32'h0,        4'b0001, 32'h0000_00AA, "lbu_400"));
    vecs.push_back(mk(1, 32'h100,  32'h2AAAA,    4'b0011, 32'h0,        "sh_100"));
    vecs.push_back(mk(0, 32'h100,  32'h0,        4'b1011, 32'hFFFF_AAAA, "lh_100"));
    vecs.push_back(mk(0, 32'h100,  32'h0,        4'b0011, 32'h0000_AAAA, "lhu_100"));
    vecs.push_back(mk(1, 32'h40,   32'hAAAA_AAAA, 4'b0111, 32'h0,        "sw_40"));
    vecs.push_back(mk(0, 32'h40,   32'h0,        4'b0111, 32'hAAAA_AAAA, "lw_40"));
    vecs.push_back(mk(1, 32'h401,  32'h11,       4'b0001, 32'h0,        "sb_401"));
    vecs.push_back(mk(0, 32'h400,  32'h0,        4'b0111, 32'h0000_11AA, "lw_merge"));
    vecs.push_back(mk(1, 32'h103,  32'h8001,     4'b0011, 32'h0,        "sh_103"));
    vecs.push_back(mk(0, 32'h102,  32'h0,        4'b1011, 32'hFFFF_8001, "lh_102"));
    vecs.push_back(mk(0, 32'h100,  32'h0,        4'b0111, 32'h8001_AAAA, "lw_100"));
    vecs.push_back(mk(0, 32'h103,  32'h0,        4'b1001, 32'hFFFF_FF80, "lb_103"));
    vecs.push_back(mk(0, 32'h101,  32'h0,        4'b1001, 32'hFFFF_FFAA, "lb_101"));
    vecs.push_back(mk(1, 32'h205,  32'h1122_3344, 4'b0000, 32'h0,        "sw_inv"));
    vecs.push_back(mk(0, 32'h204,  32'h0,        4'b0111, 32'h1122_3344, "lw_204"));
    vecs.push_back(mk(0, 32'h1204, 32'h0,        4'b0111, 32'h1122_3344, "lw_alias"));
    vecs.push_back(mk(0, 32'h204,  32'h0,        4'b1010, 32'h1122_3344, "l_inv"));
    vecs.push_back(mk(0, 32'h206,  32'h0,        4'b0011, 32'h0000_1122, "lhu_206"));

    foreach (vecs[i]) do_op(vecs[i]);

    // read_data holds while no request is pending
    repeat (4) @(negedge clk);
    check("hold_rdata", read_data, 32'h0000_1122);

    // random word stores then loads
    for (int i = 0; i < 8; i++) begin
      rnd_data[i] = {$urandom_range(0, 65535), $urandom_range(0, 65535)} & 32'hFFFF_FFFF;
      do_op(mk(1, 32'h600 + 32'(i * 4), rnd_data[i], 4'b0111, 32'h0, "rnd_sw"));
    end
    for (int i = 0; i < 8; i++)
      do_op(mk(0, 32'h600 + 32'(i * 4), 32'h0, 4'b0111, rnd_data[i], "rnd_lw"));

    // LED register
`ifdef DATA_MEM_LED_EN
    led_exp = 8'h5A;
`else
    led_exp = 8'h00;
`endif
    do_op(mk(1, 32'h2000, 32'h0000_005A, 4'b0111, 32'h0, "sw_led"));
    check("led_value", {24'd0, led}, {24'd0, led_exp});
    do_op(mk(0, 32'h2000, 32'h0, 4'b0111, 32'h0000_005A, "lw_led"));

    // reset during READ_BUFFER of a store
    do_op(mk(1, 32'h80, 32'h1234_5678, 4'b0111, 32'h0, "sw_80"));
    @(negedge clk);
    addr       = 32'h80;
    write_data = 32'hDEAD_BEEF;
    sign_mask  = 4'b0111;
    memwrite   = 1'b1;
    @(posedge clk);
    #1;
    memwrite = 1'b0;
    check("mid_store_busy", {31'd0, clk_stall}, 32'd1);
    reset = 1'b1;
    #1;
    check("rst_abort_stall", {31'd0, clk_stall}, 32'd0);
    check("rst_abort_rdata", read_data, 32'h0);
    check("rst_abort_led", {24'd0, led}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    cyc = 0;
    repeat (4) begin
      @(negedge clk);
      if (clk_stall) cyc++;
    end
    check("post_rst_idle", cyc, 32'd0);
    do_op(mk(0, 32'h80, 32'h0, 4'b0111, 32'h1234_5678, "lw_80_old"));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // global time limit
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $finish;
  end

endmodule
